ofifo_drain_ctrl: RTL and testbench
===================================

# ofifo_drain_ctrl

Sequencer that drains the output FIFO of the systolic array into the psum SRAM. Software issues a drain request with a base address and a row count. The block then pulses the FIFO read strobe whenever a full row is available, captures the returned row after the FIFO's read latency, and writes it to consecutive SRAM addresses. It sits between the OFIFO and the psum SRAM, under the top-level core controller.

## Interface
- `col`, default 8: number of array columns (lanes per row).
- `psum_bw`, default 16: bits per lane, signed two's complement.
- `addr_bw`, default 11: SRAM address width.
- `cnt_bw`, default 11: width of the row-count field.
- `RD_LAT`, default 2: cycles from `ofifo_rd` high to the row being valid on `ofifo_out`. The range is 1..4.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `start`  in  1  drain request; sampled only in IDLE.
- `base_addr`  in  addr_bw  first SRAM address; captured on accepted `start`.
- `num_rows`  in  cnt_bw  rows to drain; captured on accepted `start`.
- `ofifo_valid`  in  1  OFIFO `o_valid`: every column FIFO is non-empty.
- `ofifo_out`  in  col*psum_bw  OFIFO row data.
- `ofifo_rd`  out  1  one-cycle read strobe to the OFIFO.
- `sram_cen`  out  1  SRAM chip enable, active-low.
- `sram_wen`  out  1  SRAM write enable, active-low.
- `sram_addr`  out  addr_bw  SRAM write address.
- `sram_d`  out  col*psum_bw  SRAM write data.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the last row has been written.

## Operation
- FSM states are IDLE, DRAIN and DONE.
- **IDLE**
  - With `start`=1, the block captures `base_addr`, `num_rows` and clears the `issued`, `written` and `inflight` state.
  - If `num_rows`=0 it goes to DONE; otherwise it goes to DRAIN.
- **DRAIN, read issue**
  - `ofifo_rd`=1 when `ofifo_valid` && !`inflight` && `issued`<`num_rows`.
  - The same cycle sets `inflight` and increments `issued`.
  - At most one read is ever outstanding. This prevents over-reading, because `ofifo_valid` does not reflect a pop until the read latency has elapsed.
- **DRAIN, write-back**
  - An RD_LAT-deep valid shift register tracks the outstanding read.
  - When the register's last stage is set, the block drives `sram_cen`=0, `sram_wen`=0, `sram_addr`=`base_addr`+`written` (mod 2^addr_bw) and `sram_d`=`ofifo_out` (processed per Configuration).
  - In that same cycle it clears `inflight` and increments `written`.
  - When that write makes `written`=`num_rows`, the next state is DONE.
- **DONE**: `done`=1 for exactly one cycle, then the FSM returns to IDLE.
- `start` is ignored while `busy`=1.
- SRAM address wrap-around is silent; there is no error flag.
- An `ofifo_valid` drop in DRAIN only stalls read issue. Outstanding reads still complete.
- Reset asserted mid-drain returns the FSM to IDLE immediately. The row in flight is lost and is not written.

## Timing
- Reset values:
  - `ofifo_rd`=0, `sram_cen`=1, `sram_wen`=1, `sram_addr`=0, `sram_d`=0, `busy`=0, `done`=0.
  - All counters 0, FSM in IDLE.
- All outputs are registered.
- `busy` rises the cycle after an accepted `start`.
- If `ofifo_valid` is already high, the first `ofifo_rd` comes one cycle after `busy` rises.
- An SRAM write occurs RD_LAT cycles after its `ofifo_rd`.
- Throughput is one row per RD_LAT+1 cycles while `ofifo_valid` stays high.
- `done` is asserted one cycle after the final SRAM write.
- `busy` deasserts together with the cycle after `done`.
- For `num_rows`=0:
  - `busy`=1 for one cycle, with `done`=1 in the following cycle.
  - No `ofifo_rd` and no SRAM access.

## Configuration
- Macro `OFIFO_DRAIN_RELU_EN`.
- Defined: each `psum_bw` lane of `sram_d` is ReLU-clamped, so a negative lane becomes 0 and a non-negative lane passes unchanged. No added latency.
- Undefined: `sram_d` equals `ofifo_out` bit-exact.

## Structure
- Shared package `ofifo_drain_pkg` holds:
  - the FSM state typedef (IDLE/DRAIN/DONE);
  - the RD_LAT bounds constants;
  - the lane-slice helper.
- One natural sub-module: `psum_relu_lane`, a per-lane clamp instantiated `col` times under `OFIFO_DRAIN_RELU_EN`.

## Test plan
- Reset held low mid-drain, then released → all outputs at reset values, FSM in IDLE, no SRAM write of the in-flight row.
- Basic drain:
  - Stimulus: `base_addr`=0x010, `num_rows`=4, `ofifo_valid` held 1, RD_LAT=2.
  - Response: 4 `ofifo_rd` pulses 3 cycles apart.
  - Writes to 0x010..0x013 with data matching the rows.
  - `done` one cycle after the 0x013 write.
- `ofifo_valid` low for 5 cycles after the second read → no reads during the gap; the third read resumes the cycle after `ofifo_valid` rises; total of exactly 4 writes.
- Wrap-around: `base_addr`=0x7FE, `num_rows`=3, addr_bw=11 → writes to 0x7FE, 0x7FF, 0x000.
- Boundary and start handling:
  - `num_rows`=0 → `done` 2 cycles after `start`, zero reads and zero writes.
  - `start` pulsed while `busy` → ignored.
- Under `OFIFO_DRAIN_RELU_EN`: a row with lanes {-5, 7, -32768, 0} → `sram_d` lanes {0, 7, 0, 0}.
- Without the macro, the same row → written unchanged.

Source files
------------

// File: rtl/ofifo_drain_pkg.sv
// Shared FSM state type, read-latency bounds and lane-slice helper for the
// OFIFO drain sequencer.
`timescale 1ns/1ps
package ofifo_drain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } drain_state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  // Bit offset of lane 'lane' inside a packed row of lane_bw-bit lanes.
  function automatic int lane_lsb(input int lane, input int lane_bw);
    return lane * lane_bw;
  endfunction

endpackage

// File: rtl/ofifo_drain_ctrl_relu.sv
// Per-lane ReLU clamp: a negative signed lane becomes zero when relu_en is set,
// otherwise the lane passes through bit-exact.
`timescale 1ns/1ps
module psum_relu_lane #(
  parameter int psum_bw = 16,
  parameter bit relu_en = 1'b1
) (
  input  logic [psum_bw-1:0] psum,
  output logic [psum_bw-1:0] clamped
);

  assign clamped = (relu_en && psum[psum_bw-1]) ? '0 : psum;

endmodule

// File: rtl/ofifo_drain_ctrl.sv
// Drains rows from the systolic-array output FIFO into consecutive psum SRAM
// addresses. Build macro OFIFO_DRAIN_RELU_EN clamps negative lanes to zero.
`timescale 1ns/1ps
module ofifo_drain_ctrl
  import ofifo_drain_pkg::*;
#(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int addr_bw = 11,
  parameter int cnt_bw  = 11,
  parameter int RD_LAT  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [addr_bw-1:0]     base_addr,
  input  logic [cnt_bw-1:0]      num_rows,
  input  logic                   ofifo_valid,
  input  logic [col*psum_bw-1:0] ofifo_out,
  output logic                   ofifo_rd,
  output logic                   sram_cen,
  output logic                   sram_wen,
  output logic [addr_bw-1:0]     sram_addr,
  output logic [col*psum_bw-1:0] sram_d,
  output logic                   busy,
  output logic                   done
);

  localparam int row_bw = col * psum_bw;

`ifdef OFIFO_DRAIN_RELU_EN
  localparam bit relu_en = 1'b1;
`else
  localparam bit relu_en = 1'b0;
`endif

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_lat_check
    $error("ofifo_drain_ctrl: RD_LAT outside supported range");
  end

  drain_state_t         state;
  drain_state_t         state_next;
  logic [addr_bw-1:0]   base_q;
  logic [cnt_bw-1:0]    rows_q;
  logic [cnt_bw-1:0]    issued;
  logic [cnt_bw-1:0]    written;
  logic [cnt_bw-1:0]    written_inc;
  logic                 inflight;
  logic                 issue;
  logic                 wb;
  logic [RD_LAT-1:0]    vld;
  logic [row_bw-1:0]    row_proc;

  assign written_inc = written + cnt_bw'(1);

  for (genvar g = 0; g < col; g++) begin : g_lane
    psum_relu_lane #(
      .psum_bw (psum_bw),
      .relu_en (relu_en)
    ) u_lane (
      .psum    (ofifo_out[lane_lsb(g, psum_bw) +: psum_bw]),
      .clamped (row_proc[lane_lsb(g, psum_bw) +: psum_bw])
    );
  end

  // Only one read may be outstanding: ofifo_valid lags a pop by the read
  // latency, so issuing on it alone would over-read the FIFO.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    wb         = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = (num_rows == '0) ? DONE : DRAIN;
      end
      DRAIN: begin
        issue = ofifo_valid && !inflight && (issued < rows_q);
        wb    = vld[RD_LAT-1];
        if (wb && (written_inc == rows_q)) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_q    <= '0;
      rows_q    <= '0;
      issued    <= '0;
      written   <= '0;
      inflight  <= 1'b0;
      vld       <= '0;
      ofifo_rd  <= 1'b0;
      sram_cen  <= 1'b1;
      sram_wen  <= 1'b1;
      sram_addr <= '0;
      sram_d    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      ofifo_rd <= issue;
      sram_cen <= ~wb;
      sram_wen <= ~wb;
      busy     <= (state_next != IDLE);
      done     <= (state == DONE);
      vld[0]   <= issue;
      for (int i = 1; i < RD_LAT; i++) vld[i] <= vld[i-1];
      if (state == IDLE && start) begin
        base_q   <= base_addr;
        rows_q   <= num_rows;
        issued   <= '0;
        written  <= '0;
        inflight <= 1'b0;
        vld      <= '0;
      end else begin
        if (issue) begin
          inflight <= 1'b1;
          issued   <= issued + cnt_bw'(1);
        end
        // Address wraps silently modulo 2^addr_bw.
        if (wb) begin
          inflight  <= 1'b0;
          written   <= written_inc;
          sram_addr <= base_q + addr_bw'(written);
          sram_d    <= row_proc;
        end
      end
    end
  end

endmodule

// File: tb/tb_ofifo_drain_ctrl.sv
// Directed self-checking bench for ofifo_drain_ctrl with a registered-read
// OFIFO model (RD_LAT = 2) and a write/read/done event log.
`timescale 1ns/1ps
module tb_ofifo_drain_ctrl;

  localparam int COL = 8;
  localparam int PBW = 16;
  localparam int ABW = 11;
  localparam int CBW = 11;
  localparam int LAT = 2;
  localparam int DW  = COL * PBW;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [ABW-1:0] base_addr = '0;
  logic [CBW-1:0] num_rows = '0;
  logic           ofifo_valid = 1'b0;
  logic [DW-1:0]  ofifo_out = '0;
  logic           ofifo_rd;
  logic           sram_cen;
  logic           sram_wen;
  logic [ABW-1:0] sram_addr;
  logic [DW-1:0]  sram_d;
  logic           busy;
  logic           done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int             rd_q[$];
  int             wr_cyc_q[$];
  logic [ABW-1:0] wr_addr_q[$];
  logic [DW-1:0]  wr_data_q[$];
  int             done_q[$];
  logic [DW-1:0]  row_mem [0:7];
  int             row_idx = 0;

  ofifo_drain_ctrl #(
    .col(COL), .psum_bw(PBW), .addr_bw(ABW), .cnt_bw(CBW), .RD_LAT(LAT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .num_rows(num_rows), .ofifo_valid(ofifo_valid), .ofifo_out(ofifo_out),
    .ofifo_rd(ofifo_rd), .sram_cen(sram_cen), .sram_wen(sram_wen),
    .sram_addr(sram_addr), .sram_d(sram_d), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // OFIFO model: pops on a sampled ofifo_rd and presents the row after the edge.
  always @(posedge clk) begin
    if (ofifo_rd) begin
      #1;
      ofifo_out = (row_idx < 8) ? row_mem[row_idx] : '0;
      row_idx++;
    end
  end

  always @(negedge clk) begin
    if (ofifo_rd) rd_q.push_back(cyc);
    if (!sram_cen && !sram_wen) begin
      wr_cyc_q.push_back(cyc);
      wr_addr_q.push_back(sram_addr);
      wr_data_q.push_back(sram_d);
    end
    if (done) done_q.push_back(cyc);
  end

  task automatic clear_logs();
    rd_q.delete(); wr_cyc_q.delete(); wr_addr_q.delete();
    wr_data_q.delete(); done_q.delete();
  endtask

  task automatic load_rows();
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < COL; j++)
        row_mem[i][j*PBW +: PBW] = 16'((i << 8) | (j << 4) | 5);
    row_idx = 0;
  endtask

  task automatic issue_start(input logic [ABW-1:0] b, input logic [CBW-1:0] n, output int s);
    @(negedge clk);
    start = 1'b1; base_addr = b; num_rows = n;
    @(negedge clk);
    start = 1'b0;
    s = cyc;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done_q.size() > 0) seen = 1'b1;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    int s;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (ofifo_rd !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd: got %b expected 0", ofifo_rd); end
    checks++; if (sram_cen !== 1'b1) begin errors++; $display("[TB] FAIL reset_cen: got %b expected 1", sram_cen); end
    checks++; if (sram_wen !== 1'b1) begin errors++; $display("[TB] FAIL reset_wen: got %b expected 1", sram_wen); end
    checks++; if (sram_addr !== '0) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 0", sram_addr); end
    checks++; if (sram_d !== '0) begin errors++; $display("[TB] FAIL reset_d: got %h expected 0", sram_d); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    reset = 1'b1;
    @(negedge clk);

    load_rows(); clear_logs(); ofifo_valid = 1'b1;
    issue_start(11'h040, 11'd4, s);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy: got %b expected 0", busy); end
    checks++; if (ofifo_rd !== 1'b0) begin errors++; $display("[TB] FAIL midreset_rd: got %b expected 0", ofifo_rd); end
    checks++; if (sram_cen !== 1'b1) begin errors++; $display("[TB] FAIL midreset_cen: got %b expected 1", sram_cen); end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    ofifo_valid = 1'b0;
    checks++; if (wr_cyc_q.size() !== 0) begin errors++; $display("[TB] FAIL midreset_writes: got %0d expected 0", wr_cyc_q.size()); end
    checks++; if (rd_q.size() !== 1) begin errors++; $display("[TB] FAIL midreset_reads: got %0d expected 1", rd_q.size()); end
    checks++; if (done_q.size() !== 0) begin errors++; $display("[TB] FAIL midreset_done: got %0d expected 0", done_q.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_idle: got %b expected 0", busy); end
  endtask

  task automatic test_basic_drain();
    int s; bit seen;
    load_rows(); clear_logs(); ofifo_valid = 1'b1;
    issue_start(11'h010, 11'd4, s);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy: got %b expected 1", busy); end
    wait_done(80, seen);
    ofifo_valid = 1'b0;
    checks++; if (!seen) begin errors++; $display("[TB] FAIL basic_timeout: got no done expected done"); end
    checks++; if (rd_q.size() !== 4) begin errors++; $display("[TB] FAIL basic_rd_count: got %0d expected 4", rd_q.size()); end
    for (int i = 0; i < rd_q.size() && i < 4; i++) begin
      checks++; if (rd_q[i] !== s + 1 + 3*i) begin errors++; $display("[TB] FAIL basic_rd_cycle%0d: got %0d expected %0d", i, rd_q[i], s + 1 + 3*i); end
    end
    checks++; if (wr_cyc_q.size() !== 4) begin errors++; $display("[TB] FAIL basic_wr_count: got %0d expected 4", wr_cyc_q.size()); end
    for (int i = 0; i < wr_cyc_q.size() && i < 4; i++) begin
      checks++; if (wr_cyc_q[i] !== s + 3 + 3*i) begin errors++; $display("[TB] FAIL basic_wr_cycle%0d: got %0d expected %0d", i, wr_cyc_q[i], s + 3 + 3*i); end
      checks++; if (wr_addr_q[i] !== 11'(16 + i)) begin errors++; $display("[TB] FAIL basic_wr_addr%0d: got %h expected %h", i, wr_addr_q[i], 11'(16 + i)); end
      checks++; if (wr_data_q[i] !== row_mem[i]) begin errors++; $display("[TB] FAIL basic_wr_data%0d: got %h expected %h", i, wr_data_q[i], row_mem[i]); end
    end
    checks++; if (done_q.size() !== 1) begin errors++; $display("[TB] FAIL basic_done_count: got %0d expected 1", done_q.size()); end
    if (done_q.size() > 0) begin
      checks++; if (done_q[0] !== s + 13) begin errors++; $display("[TB] FAIL basic_done_cycle: got %0d expected %0d", done_q[0], s + 13); end
    end
  endtask

  task automatic test_valid_gap();
    int s;
    int exp_rd[4];
    int exp_wr[4];
    exp_rd = '{1, 4, 10, 13};
    exp_wr = '{3, 6, 12, 15};
    load_rows(); clear_logs(); ofifo_valid = 1'b1;
    issue_start(11'h020, 11'd4, s);
    for (int i = 0; i < 80 && done_q.size() == 0; i++) begin
      @(negedge clk);
      if (cyc == s + 4) ofifo_valid = 1'b0;
      if (cyc == s + 9) ofifo_valid = 1'b1;
    end
    repeat (3) @(negedge clk);
    ofifo_valid = 1'b0;
    checks++; if (done_q.size() !== 1) begin errors++; $display("[TB] FAIL gap_done_count: got %0d expected 1", done_q.size()); end
    checks++; if (rd_q.size() !== 4) begin errors++; $display("[TB] FAIL gap_rd_count: got %0d expected 4", rd_q.size()); end
    for (int i = 0; i < rd_q.size() && i < 4; i++) begin
      checks++; if (rd_q[i] !== s + exp_rd[i]) begin errors++; $display("[TB] FAIL gap_rd_cycle%0d: got %0d expected %0d", i, rd_q[i], s + exp_rd[i]); end
    end
    checks++; if (wr_cyc_q.size() !== 4) begin errors++; $display("[TB] FAIL gap_wr_count: got %0d expected 4", wr_cyc_q.size()); end
    for (int i = 0; i < wr_cyc_q.size() && i < 4; i++) begin
      checks++; if (wr_cyc_q[i] !== s + exp_wr[i]) begin errors++; $display("[TB] FAIL gap_wr_cycle%0d: got %0d expected %0d", i, wr_cyc_q[i], s + exp_wr[i]); end
      checks++; if (wr_data_q[i] !== row_mem[i]) begin errors++; $display("[TB] FAIL gap_wr_data%0d: got %h expected %h", i, wr_data_q[i], row_mem[i]); end
    end
    if (done_q.size() > 0) begin
      checks++; if (done_q[0] !== s + 16) begin errors++; $display("[TB] FAIL gap_done_cycle: got %0d expected %0d", done_q[0], s + 16); end
    end
  endtask

  task automatic test_wrap();
    int s; bit seen;
    logic [ABW-1:0] exp_addr[3];
    exp_addr = '{11'h7FE, 11'h7FF, 11'h000};
    load_rows(); clear_logs(); ofifo_valid = 1'b1;
    issue_start(11'h7FE, 11'd3, s);
    wait_done(80, seen);
    ofifo_valid = 1'b0;
    checks++; if (!seen) begin errors++; $display("[TB] FAIL wrap_timeout: got no done expected done"); end
    checks++; if (wr_addr_q.size() !== 3) begin errors++; $display("[TB] FAIL wrap_wr_count: got %0d expected 3", wr_addr_q.size()); end
    for (int i = 0; i < wr_addr_q.size() && i < 3; i++) begin
      checks++; if (wr_addr_q[i] !== exp_addr[i]) begin errors++; $display("[TB] FAIL wrap_addr%0d: got %h expected %h", i, wr_addr_q[i], exp_addr[i]); end
    end
  endtask

  task automatic test_zero_rows();
    int s;
    load_rows(); clear_logs(); ofifo_valid = 1'b1;
    issue_start(11'h055, 11'd0, s);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL zero_busy: got %b expected 1", busy); end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL zero_done: got %b expected 1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL zero_busy_fall: got %b expected 0", busy); end
    repeat (3) @(negedge clk);
    ofifo_valid = 1'b0;
    checks++; if (rd_q.size() !== 0) begin errors++; $display("[TB] FAIL zero_reads: got %0d expected 0", rd_q.size()); end
    checks++; if (wr_cyc_q.size() !== 0) begin errors++; $display("[TB] FAIL zero_writes: got %0d expected 0", wr_cyc_q.size()); end
    checks++; if (done_q.size() !== 1) begin errors++; $display("[TB] FAIL zero_done_count: got %0d expected 1", done_q.size()); end
    if (done_q.size() > 0) begin
      checks++; if (done_q[0] !== s + 1) begin errors++; $display("[TB] FAIL zero_done_cycle: got %0d expected %0d", done_q[0], s + 1); end
    end
  endtask

  task automatic test_start_while_busy();
    int s; bit seen;
    load_rows(); clear_logs(); ofifo_valid = 1'b1;
    issue_start(11'h100, 11'd2, s);
    repeat (2) @(negedge clk);
    start = 1'b1; base_addr = 11'h300; num_rows = 11'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done(80, seen);
    ofifo_valid = 1'b0;
    checks++; if (!seen) begin errors++; $display("[TB] FAIL busy_start_timeout: got no done expected done"); end
    checks++; if (wr_addr_q.size() !== 2) begin errors++; $display("[TB] FAIL busy_start_wr_count: got %0d expected 2", wr_addr_q.size()); end
    if (wr_addr_q.size() >= 2) begin
      checks++; if (wr_addr_q[0] !== 11'h100) begin errors++; $display("[TB] FAIL busy_start_addr0: got %h expected 100", wr_addr_q[0]); end
      checks++; if (wr_addr_q[1] !== 11'h101) begin errors++; $display("[TB] FAIL busy_start_addr1: got %h expected 101", wr_addr_q[1]); end
    end
    checks++; if (rd_q.size() !== 2) begin errors++; $display("[TB] FAIL busy_start_reads: got %0d expected 2", rd_q.size()); end
    checks++; if (done_q.size() !== 1) begin errors++; $display("[TB] FAIL busy_start_done_count: got %0d expected 1", done_q.size()); end
    if (done_q.size() > 0) begin
      checks++; if (done_q[0] !== s + 7) begin errors++; $display("[TB] FAIL busy_start_done_cycle: got %0d expected %0d", done_q[0], s + 7); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL busy_start_idle: got %b expected 0", busy); end
  endtask

  task automatic test_relu_row();
    int s; bit seen;
    logic [DW-1:0] exp_row;
    load_rows(); clear_logs();
    row_mem[0] = {16'h0001, 16'h7FFF, 16'hFFFF, 16'h0064, 16'h0000, 16'h8000, 16'h0007, 16'hFFFB};
`ifdef OFIFO_DRAIN_RELU_EN
    exp_row    = {16'h0001, 16'h7FFF, 16'h0000, 16'h0064, 16'h0000, 16'h0000, 16'h0007, 16'h0000};
`else
    exp_row    = {16'h0001, 16'h7FFF, 16'hFFFF, 16'h0064, 16'h0000, 16'h8000, 16'h0007, 16'hFFFB};
`endif
    ofifo_valid = 1'b1;
    issue_start(11'h200, 11'd1, s);
    wait_done(40, seen);
    ofifo_valid = 1'b0;
    checks++; if (!seen) begin errors++; $display("[TB] FAIL relu_timeout: got no done expected done"); end
    checks++; if (wr_data_q.size() !== 1) begin errors++; $display("[TB] FAIL relu_wr_count: got %0d expected 1", wr_data_q.size()); end
    if (wr_data_q.size() > 0) begin
      checks++; if (wr_data_q[0] !== exp_row) begin errors++; $display("[TB] FAIL relu_data: got %h expected %h", wr_data_q[0], exp_row); end
      checks++; if (wr_addr_q[0] !== 11'h200) begin errors++; $display("[TB] FAIL relu_addr: got %h expected 200", wr_addr_q[0]); end
      checks++; if (wr_cyc_q[0] !== s + 3) begin errors++; $display("[TB] FAIL relu_wr_cycle: got %0d expected %0d", wr_cyc_q[0], s + 3); end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #1 reset = 1'b0;
    test_reset();
    test_basic_drain();
    test_valid_gap();
    test_wrap();
    test_zero_rows();
    test_start_while_busy();
    test_relu_row();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
